mix_columns_sequencer: RTL

- Sequences one shared mix_one_column instance over a full 128-bit AES state, one column per clock.
- Computes MixColumns for the round pipeline without instantiating four column mixers.
- Sits between the ShiftRows stage and the AddRoundKey stage.
- Uses valid/ready handshakes on both sides.

---
 rtl/aes_model_pack.sv | 24 ++
 rtl/mix_one_column.sv | 23 ++
 rtl/mix_columns_sequencer.sv | 101 ++++++++++
 3 files changed

// File: rtl/aes_model_pack.sv
// Shared AES definitions for the MixColumns sequencer slice.
//   COLUMN_SIZE_IN_BYTES / NUM_COLUMNS : state geometry (AES-128)
//   column_t : one state column. Byte 0 of the column (row 0) is element [3].
//   state_t  : full state. Column 0 is element [NUM_COLUMNS-1], which puts it
//              in the top 32 bits of the flat 128-bit vector.
//   mix_seq_state_e : sequencer FSM encoding
//   xtime    : GF(2^8) multiply by 2 with the AES polynomial 0x11b
package aes_model_pack;
  localparam int COLUMN_SIZE_IN_BYTES = 4;
  localparam int NUM_COLUMNS          = 4;

  typedef logic [COLUMN_SIZE_IN_BYTES-1:0][7:0] column_t;
  typedef column_t [NUM_COLUMNS-1:0]            state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MIX  = 2'd1,
    DONE = 2'd2
  } mix_seq_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
endpackage

// File: rtl/mix_one_column.sv
// Combinational MixColumns of a single AES column.
//   column       : input column. Row r is at column[3-r].
//   mixed_column : the column multiplied by the circulant matrix {02,03,01,01}
//                  over GF(2^8).
module mix_one_column
  import aes_model_pack::*;
(
  input  column_t column,
  output column_t mixed_column
);
  logic [7:0] a0, a1, a2, a3;

  assign a0 = column[3];
  assign a1 = column[2];
  assign a2 = column[1];
  assign a3 = column[0];

  // The 3*x terms are written as xtime(x) ^ x.
  assign mixed_column[3] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
  assign mixed_column[2] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
  assign mixed_column[1] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
  assign mixed_column[0] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
endmodule

// File: rtl/mix_columns_sequencer.sv
// Time-multiplexes one mix_one_column over a 128-bit AES state, one column
// per clock. Sits between ShiftRows and AddRoundKey.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : input handshake. in_state is captured in IDLE.
//   in_state[127:0]       : column c at [127-32c -: 32], row r at [31-8r -: 8]
//   out_valid/out_ready   : output handshake. out_state is held through stalls.
//   out_state[127:0]      : mixed state, same packing as in_state
//   busy                  : high in MIX and DONE
// Optional build macro MIX_SEQ_LAST_ROUND_BYPASS_EN adds the last_round input.
// When last_round is captured as 1, the columns are copied through unmixed.
module mix_columns_sequencer
  import aes_model_pack::state_t, aes_model_pack::column_t,
         aes_model_pack::mix_seq_state_e, aes_model_pack::IDLE,
         aes_model_pack::MIX, aes_model_pack::DONE,
         aes_model_pack::COLUMN_SIZE_IN_BYTES;
#(
  parameter int NUM_COLUMNS = 4,
  parameter int BYTE_W      = 8
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            in_valid,
  output logic                                            in_ready,
  input  logic [NUM_COLUMNS*COLUMN_SIZE_IN_BYTES*BYTE_W-1:0] in_state,
`ifdef MIX_SEQ_LAST_ROUND_BYPASS_EN
  input  logic                                            last_round,
`endif
  output logic                                            out_valid,
  input  logic                                            out_ready,
  output logic [NUM_COLUMNS*COLUMN_SIZE_IN_BYTES*BYTE_W-1:0] out_state,
  output logic                                            busy
);
  localparam int CNT_W = $clog2(NUM_COLUMNS);

  // The packed state type and the mixer assume a 4x4 byte AES-128 state.
  if (NUM_COLUMNS != 4 || BYTE_W != 8) begin : g_bad_geometry
    $error("mix_columns_sequencer supports only NUM_COLUMNS=4, BYTE_W=8");
  end

  mix_seq_state_e   state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] col_idx;
  state_t           src_q;
  state_t           res_q;
  column_t          cur_col;
  column_t          mix_col;
  column_t          res_col;

  // Column 0 occupies the most significant element of state_t.
  assign col_idx = CNT_W'(NUM_COLUMNS - 1) - cnt_q;
  assign cur_col = src_q[col_idx];

  mix_one_column u_mix (
    .column       (cur_col),
    .mixed_column (mix_col)
  );

`ifdef MIX_SEQ_LAST_ROUND_BYPASS_EN
  logic last_q;
  assign res_col = last_q ? cur_col : mix_col;

  always_ff @(posedge clk) begin
    if (rst)
      last_q <= 1'b0;
    else if (state_q == IDLE && in_valid)
      last_q <= last_round;
  end
`else
  assign res_col = mix_col;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      src_q   <= '0;
      res_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          src_q   <= in_state;
          cnt_q   <= '0;
          state_q <= MIX;
        end
        MIX: begin
          res_q[col_idx] <= res_col;
          cnt_q          <= cnt_q + 1'b1;   // wraps to 0 after the last column
          if (cnt_q == CNT_W'(NUM_COLUMNS - 1))
            state_q <= DONE;
        end
        DONE: if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_state = res_q;
endmodule
